// File: rtl/hex_display_scan.sv
// Time-multiplexed N-digit hex 7-segment scanner with a double-buffered display word,
// anode guard gaps, per-digit blanking, decimal points and leading-zero suppression.

module hex_digit_lane #(
  parameter bit IS_LSD = 1'b0
) (
  input  logic [3:0] nib,
  input  logic       zero_hi,
  input  logic       blank,
  input  logic       dp_in,
  input  logic       lz,
  output logic [6:0] seg,
  output logic       dp
);
  logic [6:0] glyph;
  logic       dark;

  always_comb begin
    glyph = 7'h7F;
    case (nib)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      4'hF: glyph = 7'b0111000;
      default: glyph = 7'h7F;
    endcase
  end

  // The least significant digit always shows, so an all-zero word still reads "0".
  assign dark = blank | (lz & zero_hi & ~IS_LSD);
  assign seg  = dark ? 7'h7F : glyph;
  assign dp   = dark | ~dp_in;
endmodule

module hex_display_scan #(
  parameter int DIGITS    = 4,
  parameter int SCAN_CYC  = 50000,
  parameter int GUARD_CYC = 16,
  parameter bit AN_LOW    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_en,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);
  localparam int CMAX = (SCAN_CYC > GUARD_CYC) ? SCAN_CYC : GUARD_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{AN_LOW}};

  typedef enum logic {GUARD = 1'b0, DRIVE = 1'b1} state_t;

  typedef struct packed {
    logic [DIGITS-1:0][3:0] value;
    logic [DIGITS-1:0]      dp;
    logic [DIGITS-1:0]      blank;
    logic                   lz;
  } disp_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [IW-1:0]   idx, idx_nx;
  logic            wrap, commit, dirty;
  disp_t           pend, act, act_nx;

  logic [DIGITS-1:0]      zhi;
  logic [DIGITS-1:0][6:0] lane_seg;
  logic [DIGITS-1:0]      lane_dp;
  logic [DIGITS-1:0]      an_on;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    idx_nx   = idx;
    wrap     = 1'b0;
    case (state)
      GUARD: begin
        if (GUARD_CYC == 0 || cnt == CW'(GUARD_CYC - 1)) begin
          state_nx = DRIVE;
          cnt_nx   = '0;
        end
      end
      DRIVE: begin
        if (cnt == CW'(SCAN_CYC - 1)) begin
          cnt_nx   = '0;
          state_nx = (GUARD_CYC == 0) ? DRIVE : GUARD;
          if (idx == IW'(DIGITS - 1)) begin
            idx_nx = '0;
            wrap   = 1'b1;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      default: begin
        state_nx = GUARD;
        cnt_nx   = '0;
      end
    endcase
  end

  // Commit happens on the wrap edge itself, so the new word drives from digit 0 onward.
  assign commit = wrap & dirty;
  assign act_nx = commit ? pend : act;

  for (genvar i = 0; i < DIGITS; i++) begin : g_lane
    if (i == DIGITS - 1) begin : g_top
      assign zhi[i] = (act_nx.value[i] == 4'h0);
    end else begin : g_mid
      assign zhi[i] = (act_nx.value[i] == 4'h0) & zhi[i+1];
    end
    hex_digit_lane #(.IS_LSD(i == 0)) u_lane (
      .nib     (act_nx.value[i]),
      .zero_hi (zhi[i]),
      .blank   (act_nx.blank[i]),
      .dp_in   (act_nx.dp[i]),
      .lz      (act_nx.lz),
      .seg     (lane_seg[i]),
      .dp      (lane_dp[i])
    );
  end

  assign an_on = DIGITS'(1) << idx_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= GUARD;
      cnt   <= '0;
      idx   <= '0;
      pend  <= '0;
      act   <= '0;
      dirty <= 1'b0;
      seg   <= 7'h7F;
      dp    <= 1'b1;
      an    <= AN_OFF;
      frame <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      act   <= act_nx;
      frame <= commit;
      // A load on the commit edge refills pending and keeps it dirty for the next frame.
      if (load) begin
        pend  <= '{value: value, dp: dp_in, blank: blank, lz: lz_en};
        dirty <= 1'b1;
      end else if (commit) begin
        dirty <= 1'b0;
      end
      if (state_nx == DRIVE) begin
        seg <= lane_seg[idx_nx];
        dp  <= lane_dp[idx_nx];
        an  <= AN_LOW ? ~an_on : an_on;
      end else begin
        seg <= 7'h7F;
        dp  <= 1'b1;
        an  <= AN_OFF;
      end
    end
  end
endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench for hex_display_scan: vector table of display words plus
// hand-written sequences for load/commit timing and mid-scan reset.

module tb_hex_display_scan;
  localparam int D = 4;
  localparam int S = 4;
  localparam int G = 2;
  localparam int FRAME = D * (S + G);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank = '0;
  logic        lz_en = 1'b0;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame;

  int   total = 0;
  int   passed = 0;
  bit   mon = 1'b0;
  logic [3:0] prev_an = 4'hF;

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic [3:0]      blank;
    logic            lz;
    logic [3:0][6:0] seg;
    logic [3:0]      dpo;
  } vec_t;

  vec_t vt [7];

  hex_display_scan #(.DIGITS(D), .SCAN_CYC(S), .GUARD_CYC(G), .AN_LOW(1'b1)) dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .dp_in (dp_in),
    .blank (blank),
    .lz_en (lz_en),
    .load  (load),
    .seg   (seg),
    .dp    (dp),
    .an    (an),
    .frame (frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask
  task automatic chk7(input string name, input logic [6:0] got, input logic [6:0] exp);
    chk(name, 32'(got), 32'(exp));
  endtask
  task automatic chk4(input string name, input logic [3:0] got, input logic [3:0] exp);
    chk(name, 32'(got), 32'(exp));
  endtask
  task automatic chk1(input string name, input logic got, input logic exp);
    chk(name, 32'(got), 32'(exp));
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Invariants watched every cycle once the first reset is done.
  always @(negedge clk) begin
    if (mon) begin
      chk1("an_onehot0", $onehot0(~an), 1'b1);
      if (an == 4'hF) chk7("dark_seg_when_no_anode", seg, 7'h7F);
      if (frame) chk4("frame_follows_last_digit", prev_an, 4'h7);
      prev_an = an;
    end
  end

  task automatic wait_frame(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 4 * FRAME; k++) begin
      step();
      if (frame) begin
        ok = 1'b1;
        break;
      end
    end
    chk1(name, ok, 1'b1);
  endtask

  task automatic wait_an(input string name, input logic [3:0] target);
    for (int k = 0; k < 4 * FRAME; k++) begin
      if (an == target) break;
      step();
    end
    chk4(name, an, target);
  endtask

  task automatic count_frames(input int n, output int c);
    c = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (frame) c++;
    end
  endtask

  // Called on the negedge where frame is high; walks one whole frame cycle by cycle.
  task automatic check_frame(input string name, input logic [3:0][6:0] es, input logic [3:0] ed);
    for (int t = 0; t < FRAME; t++) begin
      int d, p;
      logic [3:0] ea;
      if (t > 0) step();
      d = t / (S + G);
      p = t % (S + G);
      if (p < G) begin
        chk4({name, "_guard_an"}, an, 4'hF);
        chk1({name, "_guard_dp"}, dp, 1'b1);
      end else begin
        ea = 4'b0001 << d;
        ea = ~ea;
        chk4({name, "_an"}, an, ea);
        chk7({name, "_seg"}, seg, es[d]);
        chk1({name, "_dp"}, dp, ed[d]);
      end
    end
  endtask

  initial begin
    int c;
    vt[0] = '{16'h1A3F, 4'b0000, 4'b0000, 1'b0,
              {7'b1001111, 7'b0001000, 7'b0000110, 7'b0111000}, 4'b1111};
    vt[1] = '{16'h0005, 4'b0000, 4'b0000, 1'b1,
              {7'h7F, 7'h7F, 7'h7F, 7'b0100100}, 4'b1111};
    vt[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b1,
              {7'h7F, 7'h7F, 7'h7F, 7'b0000001}, 4'b1111};
    vt[3] = '{16'h1A3F, 4'b0001, 4'b0100, 1'b0,
              {7'b1001111, 7'h7F, 7'b0000110, 7'b0111000}, 4'b1110};
    vt[4] = '{16'h0A00, 4'b1000, 4'b0000, 1'b1,
              {7'h7F, 7'b0001000, 7'b0000001, 7'b0000001}, 4'b1111};
    vt[5] = '{16'hC6E9, 4'b1010, 4'b0000, 1'b0,
              {7'b0110001, 7'b0100000, 7'b0110000, 7'b0000100}, 4'b0101};
    vt[6] = '{16'h0000, 4'b0000, 4'b0001, 1'b1,
              {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b1111};

    // Reset state and first-drive latency
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk4("rst_an", an, 4'hF);
      chk7("rst_seg", seg, 7'h7F);
      chk1("rst_dp", dp, 1'b1);
      chk1("rst_frame", frame, 1'b0);
    end
    rst = 1'b0;
    mon = 1'b1;
    step();
    chk4("guard_after_rst_an", an, 4'hF);
    step();
    chk4("first_drive_an", an, 4'hE);
    chk7("first_drive_seg", seg, 7'b0000001);

    // Table of display words
    for (int i = 0; i < 7; i++) begin
      value = vt[i].value;
      dp_in = vt[i].dp;
      blank = vt[i].blank;
      lz_en = vt[i].lz;
      load  = 1'b1;
      step();
      load  = 1'b0;
      wait_frame($sformatf("vec%0d_frame", i));
      if (frame) check_frame($sformatf("vec%0d", i), vt[i].seg, vt[i].dpo);
    end

    // Two loads in one frame: only the last is committed, one pulse
    dp_in = '0;
    blank = '0;
    lz_en = 1'b0;
    wait_an("lastwins_wait_d2", 4'hB);
    value = 16'h1111;
    load  = 1'b1;
    step();
    load  = 1'b0;
    wait_an("lastwins_wait_d3", 4'h7);
    value = 16'h2222;
    load  = 1'b1;
    step();
    load  = 1'b0;
    wait_frame("lastwins_frame");
    check_frame("lastwins", {4{7'b0010010}}, 4'hF);
    count_frames(FRAME, c);
    chk("lastwins_extra_pulses", 32'(c), 32'd0);

    // Load on the commit edge is held for the following frame
    wait_an("edge_wait_d2", 4'hB);
    value = 16'h3333;
    load  = 1'b1;
    step();
    load  = 1'b0;
    wait_an("edge_wait_d3", 4'h7);
    for (int k = 0; k < S - 1; k++) step();
    chk4("edge_pre_boundary_an", an, 4'h7);
    value = 16'hCCCC;
    load  = 1'b1;
    step();
    load  = 1'b0;
    chk1("edge_boundary_pulse", frame, 1'b1);
    check_frame("edge_first", {4{7'b0000110}}, 4'hF);
    wait_frame("edge_second_frame");
    check_frame("edge_second", {4{7'b0110001}}, 4'hF);

    // Reset while digit 2 is driven; the simultaneous load is dropped
    wait_an("midrst_wait_d2", 4'hB);
    rst   = 1'b1;
    load  = 1'b1;
    value = 16'h1A3F;
    step();
    rst   = 1'b0;
    load  = 1'b0;
    chk4("midrst_an", an, 4'hF);
    chk7("midrst_seg", seg, 7'h7F);
    chk1("midrst_dp", dp, 1'b1);
    chk1("midrst_frame", frame, 1'b0);
    step();
    chk4("midrst_guard_an", an, 4'hF);
    step();
    chk4("midrst_restart_an", an, 4'hE);
    chk7("midrst_cleared_seg", seg, 7'b0000001);
    count_frames(FRAME + 6, c);
    chk("midrst_no_commit", 32'(c), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
